// File: rtl/player_pkg.sv
// Shared types and helpers for the music player playback controller.
package player_pkg;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      PLAYING = 2'd1,
      PAUSED  = 2'd2,
      ADVANCE = 2'd3
   } player_state_e;

   typedef struct packed {
      logic [3:0] m0;
      logic [3:0] s1;
      logic [3:0] s0;
   } bcd_time_t;

   localparam int TRACK_LEN_W = 12;

   function automatic logic bcd_time_eq(input bcd_time_t a, input bcd_time_t b);
      return (a.m0 == b.m0) && (a.s1 == b.s1) && (a.s0 == b.s0);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ cycles while run_i is high.
// clear_i has priority over run_i; with neither asserted the phase is held.
module tick_prescaler #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/playback_controller.sv
// Play/pause/stop/next/prev sequencer with 1 Hz timer control and end-of-track detect.
// Build option REPEAT_ALL_EN: last track wraps to track 0 and keeps playing.
//
// state   | meaning
// STOPPED | idle, timer cleared, next/prev only move the track index
// PLAYING | timer counting, prescaler running, end detect active
// PAUSED  | timer and prescaler phase held
// ADVANCE | one-cycle track change, then back to PLAYING or PAUSED
module playback_controller
   import player_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int NUM_TRACKS     = 4,
   parameter int PREV_RESTART_S = 3,
   localparam int IDX_W         = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              btn_play_pause,
   input  logic                              btn_stop,
   input  logic                              btn_next,
   input  logic                              btn_prev,
   input  logic [3:0]                        sec0,
   input  logic [3:0]                        sec1,
   input  logic [3:0]                        min0,
   input  logic [TRACK_LEN_W*NUM_TRACKS-1:0] track_len,
   output logic                              tick_1hz,
   output logic                              timer_count,
   output logic                              timer_clear,
   output logic [IDX_W-1:0]                  track_idx,
   output logic                              playing,
   output logic                              end_of_track
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRACKS - 1);

   player_state_e    state_q, state_d;
   player_state_e    ret_q, ret_d;
   logic [IDX_W-1:0] track_idx_q, track_idx_d;
   logic             timer_clear_q, timer_clear_d;
   logic             eot_q, eot_d;
   logic             playing_q, count_q;

   logic [IDX_W-1:0] idx_inc, idx_dec;
   logic             prev_restart;
   logic             at_end;
   bcd_time_t        cur_time, cur_len;

   assign cur_time = {min0, sec1, sec0};
   assign cur_len  = bcd_time_t'(track_len[TRACK_LEN_W*32'(track_idx_q) +: TRACK_LEN_W]);
   assign at_end   = bcd_time_eq(cur_time, cur_len);

   assign idx_inc = (track_idx_q == LAST_IDX) ? '0 : track_idx_q + 1'b1;
   assign idx_dec = (track_idx_q == '0) ? LAST_IDX : track_idx_q - 1'b1;

   assign prev_restart = ({min0, sec1} != 8'd0) || (sec0 >= 4'(PREV_RESTART_S));

   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      track_idx_d   = track_idx_q;
      timer_clear_d = 1'b0;
      eot_d         = 1'b0;
      case (state_q)
         STOPPED: begin
            if (btn_stop) begin
               state_d = STOPPED;
            end else if (btn_next) begin
               track_idx_d = idx_inc;
            end else if (btn_prev) begin
               if (prev_restart) timer_clear_d = 1'b1;
               else              track_idx_d   = idx_dec;
            end else if (btn_play_pause) begin
               state_d = PLAYING;
            end
         end
         PLAYING, PAUSED: begin
            if (btn_stop) begin
               state_d       = STOPPED;
               timer_clear_d = 1'b1;
            end else if (btn_next || btn_prev) begin
               state_d       = ADVANCE;
               ret_d         = state_q;
               timer_clear_d = 1'b1;
               if (btn_next)          track_idx_d = idx_inc;
               else if (!prev_restart) track_idx_d = idx_dec;
            end else if (btn_play_pause) begin
               state_d = (state_q == PLAYING) ? PAUSED : PLAYING;
            end else if ((state_q == PLAYING) && at_end) begin
               eot_d         = 1'b1;
               timer_clear_d = 1'b1;
               track_idx_d   = idx_inc;
               ret_d         = PLAYING;
`ifdef REPEAT_ALL_EN
               state_d       = ADVANCE;
`else
               // Running off the last track ends the playlist.
               state_d       = (track_idx_q == LAST_IDX) ? STOPPED : ADVANCE;
`endif
            end
         end
         ADVANCE: begin
            if (btn_stop) begin
               state_d       = STOPPED;
               timer_clear_d = 1'b1;
            end else begin
               state_d = ret_q;
            end
         end
         default: begin
            state_d       = STOPPED;
            timer_clear_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= STOPPED;
         ret_q         <= PLAYING;
         track_idx_q   <= '0;
         timer_clear_q <= 1'b1;
         eot_q         <= 1'b0;
         playing_q     <= 1'b0;
         count_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ret_q         <= ret_d;
         track_idx_q   <= track_idx_d;
         timer_clear_q <= timer_clear_d;
         eot_q         <= eot_d;
         playing_q     <= (state_d == PLAYING);
         count_q       <= (state_d == PLAYING);
      end
   end

   tick_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .run_i   (state_q == PLAYING),
      .clear_i ((state_q == STOPPED) || (state_q == ADVANCE)),
      .tick_o  (tick_1hz)
   );

   assign timer_count  = count_q;
   assign timer_clear  = timer_clear_q;
   assign track_idx    = track_idx_q;
   assign playing      = playing_q;
   assign end_of_track = eot_q;

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench for playback_controller with CLK_HZ=4 and a BCD timer model driven by its outputs.
module tb_playback_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_play_pause, btn_stop, btn_next, btn_prev;
   logic [47:0] track_len;
   logic        tick_1hz, timer_count, timer_clear, playing, end_of_track;
   logic [1:0]  track_idx;

   logic [11:0] tmr = 12'h000;
   logic        ld;
   logic [11:0] ld_val;

   int total = 0;
   int bad   = 0;

`ifdef REPEAT_ALL_EN
   localparam logic REPEAT = 1'b1;
`else
   localparam logic REPEAT = 1'b0;
`endif

   always #5 clk = ~clk;

   playback_controller #(
      .CLK_HZ         (4),
      .NUM_TRACKS     (4),
      .PREV_RESTART_S (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .btn_play_pause (btn_play_pause),
      .btn_stop       (btn_stop),
      .btn_next       (btn_next),
      .btn_prev       (btn_prev),
      .sec0           (tmr[3:0]),
      .sec1           (tmr[7:4]),
      .min0           (tmr[11:8]),
      .track_len      (track_len),
      .tick_1hz       (tick_1hz),
      .timer_count    (timer_count),
      .timer_clear    (timer_clear),
      .track_idx      (track_idx),
      .playing        (playing),
      .end_of_track   (end_of_track)
   );

   // External M:SS BCD timer; a bench load overrides it to set up prev cases.
   always @(posedge clk) begin
      if (ld) tmr <= ld_val;
      else if (timer_clear) tmr <= 12'h000;
      else if (tick_1hz) begin
         if (tmr[3:0] != 4'd9) tmr[3:0] <= tmr[3:0] + 4'd1;
         else begin
            tmr[3:0] <= 4'd0;
            if (tmr[7:4] != 4'd5) tmr[7:4] <= tmr[7:4] + 4'd1;
            else begin
               tmr[7:4]  <= 4'd0;
               tmr[11:8] <= tmr[11:8] + 4'd1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic press(input int which);
      case (which)
         0: btn_play_pause = 1'b1;
         1: btn_stop       = 1'b1;
         2: btn_next       = 1'b1;
         default: btn_prev = 1'b1;
      endcase
      step();
      btn_play_pause = 1'b0;
      btn_stop       = 1'b0;
      btn_next       = 1'b0;
      btn_prev       = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tick"}, tick_1hz, 0);
      chk({tag, "_count"}, timer_count, 0);
      chk({tag, "_clear"}, timer_clear, 1);
      chk({tag, "_idx"}, track_idx, 0);
      chk({tag, "_playing"}, playing, 0);
      chk({tag, "_eot"}, end_of_track, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      btn_play_pause = 1'b0; btn_stop = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
      ld = 1'b0; ld_val = 12'h000;
      track_len = {12'h001, 12'h030, 12'h030, 12'h009};
      repeat (3) step();
      chk_reset_vals("rst");
      reset = 1'b0;
      step();

      // Tick cadence after play
      press(0);
      chk("play_playing", playing, 1);
      chk("play_count", timer_count, 1);
      chk("play_clear", timer_clear, 0);
      for (int i = 1; i <= 12; i++) begin
         step();
         chk($sformatf("tick_c%0d", i), tick_1hz, (i % 4 == 0) ? 1 : 0);
      end

      // Reset mid-play, then natural end of a 0:02 track 0
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_mid_play");
      step();
      reset = 1'b0;
      track_len[11:0] = 12'h002;
      step();
      press(0);
      repeat (9) step();
      chk("end_pre_time", tmr, 12'h002);
      chk("end_pre_eot", end_of_track, 0);
      step();
      chk("end_eot", end_of_track, 1);
      chk("end_idx", track_idx, 1);
      chk("end_clear", timer_clear, 1);
      chk("end_adv_playing", playing, 0);
      step();
      chk("end_resume_playing", playing, 1);
      chk("end_resume_eot", end_of_track, 0);
      chk("end_resume_clear", timer_clear, 0);
      chk("end_resume_time", tmr, 12'h000);

      // Pause after two prescaler counts, hold, resume
      step();
      press(0);
      chk("pause_playing", playing, 0);
      chk("pause_count", timer_count, 0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("pause_hold_count", timer_count, 0);
         chk("pause_hold_tick", tick_1hz, 0);
      end
      press(0);
      chk("resume_playing", playing, 1);
      step();
      chk("resume_tick_c1", tick_1hz, 0);
      step();
      chk("resume_tick_c2", tick_1hz, 1);

      // Prev at 0:05 restarts track 1
      ld = 1'b1; ld_val = 12'h005;
      step();
      ld = 1'b0;
      press(3);
      chk("prev_rst_idx", track_idx, 1);
      chk("prev_rst_clear", timer_clear, 1);
      chk("prev_rst_adv", playing, 0);
      step();
      chk("prev_rst_playing", playing, 1);
      chk("prev_rst_time", tmr, 12'h000);

      // Prev at 0:00 to track 0, prev at 0:01 wraps to track 3
      press(3);
      chk("prev_dec_idx", track_idx, 0);
      chk("prev_dec_clear", timer_clear, 1);
      step();
      chk("prev_dec_playing", playing, 1);
      ld = 1'b1; ld_val = 12'h001;
      step();
      ld = 1'b0;
      press(3);
      chk("prev_wrap_idx", track_idx, 3);
      chk("prev_wrap_clear", timer_clear, 1);
      track_len[11:0] = 12'h059;
      step();
      chk("prev_wrap_playing", playing, 1);

      // Next on track 3 wraps to 0
      press(2);
      chk("next_wrap_idx", track_idx, 0);
      chk("next_wrap_eot", end_of_track, 0);
      chk("next_wrap_clear", timer_clear, 1);
      step();
      chk("next_wrap_playing", playing, 1);

      // Stop, next and play_pause together: stop wins
      btn_stop = 1'b1; btn_next = 1'b1; btn_play_pause = 1'b1;
      step();
      btn_stop = 1'b0; btn_next = 1'b0; btn_play_pause = 1'b0;
      chk("multi_playing", playing, 0);
      chk("multi_count", timer_count, 0);
      chk("multi_idx", track_idx, 0);
      chk("multi_clear", timer_clear, 1);
      step();
      chk("multi_clear_end", timer_clear, 0);
      chk("multi_stopped", playing, 0);

      // End of last track (0:01)
      press(3);
      chk("stop_prev_idx", track_idx, 3);
      chk("stop_prev_clear", timer_clear, 0);
      chk("stop_prev_playing", playing, 0);
      press(0);
      chk("last_play", playing, 1);
      repeat (5) step();
      chk("last_pre_time", tmr, 12'h001);
      chk("last_pre_eot", end_of_track, 0);
      step();
      chk("last_eot", end_of_track, 1);
      chk("last_idx", track_idx, 0);
      chk("last_clear", timer_clear, 1);
      chk("last_playing_c0", playing, 0);
      step();
      chk("last_eot_end", end_of_track, 0);
      chk("last_playing_c1", playing, REPEAT);
      chk("last_count_c1", timer_count, REPEAT);

      // Reset while in ADVANCE
      press(1);
      chk("adv_stopped", playing, 0);
      press(0);
      chk("adv_play", playing, 1);
      press(2);
      chk("adv_idx", track_idx, 1);
      chk("adv_playing", playing, 0);
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_mid_adv");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
